shift_control_unit: RTL

Sequencing controller for the two-register shift datapath (reg_A/reg_B register unit). It turns operator-level controls (Execute, LoadA, LoadB) into the Ld_A, Ld_B and Shift_En strobes. Each Execute runs exactly N_BITS shift cycles, and the unit never re-triggers until Execute is released. It sits between the debounced switch/button inputs and the register unit in the lab top level.

---
 rtl/lab2_pkg.sv | 17 +
 rtl/shift_control_unit.sv | 139 +++++++++++++
 2 files changed

// File: rtl/lab2_pkg.sv
// -----------------------------------------------------------------------------
// lab2_pkg
// Shared definitions for the lab-2 shift datapath.
//   ctrl_state_t : sequencing states of shift_control_unit
//   REG_W        : default register width, also the default shift count
// -----------------------------------------------------------------------------
package lab2_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } ctrl_state_t;

  localparam int REG_W = 4;

endpackage

// File: rtl/shift_control_unit.sv
// -----------------------------------------------------------------------------
// shift_control_unit
// Turns operator-level controls into load/shift strobes for the two-register
// shift datapath. Each Execute runs exactly N_BITS shift cycles, then the unit
// waits in HOLD until Execute is released so a held button never re-triggers.
//
// Ports
//   Clk      : system clock, rising-edge active
//   Reset    : synchronous, active-high
//   Execute  : start an operation (level, debounced)
//   LoadA    : request parallel load of register A (honoured only in IDLE)
//   LoadB    : request parallel load of register B (honoured only in IDLE)
//   Ld_A     : load strobe to register A (combinational in IDLE)
//   Ld_B     : load strobe to register B (combinational in IDLE)
//   Shift_En : shift strobe to both registers
//   Busy     : operation in progress (SHIFT or HOLD)
//   Done     : one-cycle pulse in the first HOLD cycle
//   Bit_Cnt  : shifts completed in the current/last operation
// -----------------------------------------------------------------------------
module shift_control_unit
  import lab2_pkg::*;
#(
  parameter  int N_BITS = REG_W,
  localparam int CNT_W  = $clog2(N_BITS + 1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Execute,
  input  logic             LoadA,
  input  logic             LoadB,
  output logic             Ld_A,
  output logic             Ld_B,
  output logic             Shift_En,
  output logic             Busy,
  output logic             Done,
  output logic [CNT_W-1:0] Bit_Cnt
);

  // Counter value seen during the final shift cycle; comparing here (not at
  // N_BITS) keeps the counter from ever wrapping.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  ctrl_state_t      state_r;
  ctrl_state_t      next_state_s;
  logic [CNT_W-1:0] bit_cnt_r;
  logic             done_r;
  logic             last_shift_s;
  logic             ld_a_s;
  logic             ld_b_s;
  logic             shift_en_s;
  logic             busy_s;

  assign last_shift_s = (state_r == SHIFT) && (bit_cnt_r == LAST_CNT);

  // Next-state decode and strobe generation; Reset masks strobes immediately.
  always_comb begin
    next_state_s = state_r;
    ld_a_s       = 1'b0;
    ld_b_s       = 1'b0;
    shift_en_s   = 1'b0;
    busy_s       = 1'b0;
    case (state_r)
      IDLE: begin
        // Execute wins over a simultaneous load request.
        ld_a_s = LoadA & ~Execute & ~Reset;
        ld_b_s = LoadB & ~Execute & ~Reset;
        if (Execute) begin
          next_state_s = SHIFT;
        end else begin
          next_state_s = IDLE;
        end
      end
      SHIFT: begin
        shift_en_s = ~Reset;
        busy_s     = 1'b1;
        if (bit_cnt_r == LAST_CNT) begin
          next_state_s = HOLD;
        end else begin
          next_state_s = SHIFT;
        end
      end
      HOLD: begin
        busy_s = 1'b1;
        if (Execute) begin
          next_state_s = HOLD;
        end else begin
          next_state_s = IDLE;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State register and shift counter.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r   <= IDLE;
      bit_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= next_state_s;
      case (state_r)
        IDLE: begin
          if (Execute) begin
            bit_cnt_r <= {CNT_W{1'b0}};
          end else begin
            bit_cnt_r <= bit_cnt_r;
          end
        end
        SHIFT: begin
          bit_cnt_r <= bit_cnt_r + CNT_ONE;
        end
        default: begin
          bit_cnt_r <= bit_cnt_r;
        end
      endcase
    end
  end

  // Done pulse: registered from the final shift cycle, so it lands in the
  // first HOLD cycle only.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      done_r <= 1'b0;
    end else begin
      done_r <= last_shift_s;
    end
  end

  assign Ld_A     = ld_a_s;
  assign Ld_B     = ld_b_s;
  assign Shift_En = shift_en_s;
  assign Busy     = busy_s;
  assign Done     = done_r;
  assign Bit_Cnt  = bit_cnt_r;

endmodule
